busca_instrucao: RTL and testbench

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

---
 rtl/busca_instrucao.sv | 71 +++++++
 tb/tb_busca_instrucao.sv | 133 +++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - instruction fetch stage with branch redirect, stall hold and halt detection
module busca_instrucao #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  input  logic       stall,
  input  logic       desvio,
  input  logic [7:0] alvo,
  output logic [7:0] instr,
  output logic [7:0] pc_instr,
  output logic       valid,
  output logic       parado
);

  typedef enum logic {EXECUTA = 1'b0, PARADO = 1'b1} estado_t;

  estado_t    state;
  estado_t    state_next;
  logic [7:0] pc;
  logic       halt_hit;

  assign imem_addr = pc;
  assign halt_hit  = valid && (instr == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (reset) state <= EXECUTA;
    else       state <= state_next;
  end

  // Halting only wins when neither a branch nor a stall claims the edge.
  always_comb begin
    state_next = state;
    if (state == EXECUTA && !desvio && !stall && halt_hit)
      state_next = PARADO;
  end

  always_comb begin
    parado = (state == PARADO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      instr    <= 8'h00;
      pc_instr <= 8'h00;
      valid    <= 1'b0;
    end else if (state == EXECUTA) begin
      if (desvio) begin
        pc       <= alvo;
        instr    <= 8'h00;
        pc_instr <= 8'h00;
        valid    <= 1'b0;
      end else if (!stall) begin
        // A live halt word freezes pc and the instruction registers.
        if (halt_hit) begin
          valid <= 1'b0;
        end else begin
          instr    <= imem_data;
          pc_instr <= pc;
          valid    <= 1'b1;
          pc       <= pc + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// tb/tb_busca_instrucao.sv - directed vector bench for busca_instrucao
module tb_busca_instrucao;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       stall;
  logic       desvio;
  logic [7:0] alvo;
  logic [7:0] instr;
  logic [7:0] pc_instr;
  logic       valid;
  logic       parado;

  logic [7:0] rom [256];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       stl;
    logic       dsv;
    logic [7:0] tgt;
    logic [7:0] e_instr;
    logic [7:0] e_pc;
    logic       e_valid;
    logic       e_parado;
    logic [7:0] e_addr;
  } vec_t;

  vec_t vecs [17];

  busca_instrucao dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .stall     (stall),
    .desvio    (desvio),
    .alvo      (alvo),
    .instr     (instr),
    .pc_instr  (pc_instr),
    .valid     (valid),
    .parado    (parado)
  );

  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic s, input logic d, input logic [7:0] a);
    reset  = r;
    stall  = s;
    desvio = d;
    alvo   = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] ei, input logic [7:0] ep,
                     input logic ev, input logic epar, input logic [7:0] ea);
    checks++;
    if (instr !== ei || pc_instr !== ep || valid !== ev || parado !== epar || imem_addr !== ea) begin
      errors++;
      $display("FAIL %s: got instr=%h pc_instr=%h valid=%b parado=%b addr=%h, want instr=%h pc_instr=%h valid=%b parado=%b addr=%h",
               name, instr, pc_instr, valid, parado, imem_addr, ei, ep, ev, epar, ea);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h11; rom[8'h01] = 8'h22; rom[8'h02] = 8'h33; rom[8'h03] = 8'h44;
    rom[8'hF0] = 8'hA5; rom[8'hF1] = 8'hB6; rom[8'h10] = 8'h77;

    //           rst   stl   dsv   alvo   instr  pc     v     par   addr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 8'h00, 1'b1, 1'b0, 8'h01};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h22, 8'h01, 1'b1, 1'b0, 8'h02};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 8'h01, 1'b1, 1'b0, 8'h02};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 8'h01, 1'b1, 1'b0, 8'h02};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 8'h01, 1'b1, 1'b0, 8'h02};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h33, 8'h02, 1'b1, 1'b0, 8'h03};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'hF0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 8'hF0, 1'b1, 1'b0, 8'hF1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hB6, 8'hF1, 1'b1, 1'b0, 8'hF2};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'hF0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 8'hF0, 1'b1, 1'b0, 8'hF1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'hF0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 8'hF0, 1'b1, 1'b0, 8'hF1};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 8'h00, 1'b1, 1'b0, 8'h01};

    reset = 1'b1; stall = 1'b0; desvio = 1'b0; alvo = 8'h00;
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rst, vecs[i].stl, vecs[i].dsv, vecs[i].tgt);
      chk($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_valid,
          vecs[i].e_parado, vecs[i].e_addr);
    end

    // Wrap from FF to 00 without a bubble
    rom[8'hFE] = 8'h01; rom[8'hFF] = 8'h02; rom[8'h00] = 8'h03;
    step(1'b0, 1'b0, 1'b1, 8'hFE); chk("wrap_bubble", 8'h00, 8'h00, 1'b0, 1'b0, 8'hFE);
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("wrap_fe",     8'h01, 8'hFE, 1'b1, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("wrap_ff",     8'h02, 8'hFF, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("wrap_00",     8'h03, 8'h00, 1'b1, 1'b0, 8'h01);

    // Halt: stall delays entry, then PARADO ignores desvio/stall until reset
    rom[8'h00] = 8'h11; rom[8'h01] = 8'h22; rom[8'h02] = 8'hFF;
    step(1'b1, 1'b0, 1'b0, 8'h00); chk("halt_rst",    8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("halt_f0",     8'h11, 8'h00, 1'b1, 1'b0, 8'h01);
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("halt_f1",     8'h22, 8'h01, 1'b1, 1'b0, 8'h02);
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("halt_word",   8'hFF, 8'h02, 1'b1, 1'b0, 8'h03);
    step(1'b0, 1'b1, 1'b0, 8'h00); chk("halt_stall",  8'hFF, 8'h02, 1'b1, 1'b0, 8'h03);
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("halt_enter",  8'hFF, 8'h02, 1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b0, 1'b1, 8'h10); chk("halt_desvio", 8'hFF, 8'h02, 1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b1, 1'b1, 8'h20); chk("halt_both",   8'hFF, 8'h02, 1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("halt_hold",   8'hFF, 8'h02, 1'b0, 1'b1, 8'h03);
    step(1'b1, 1'b1, 1'b1, 8'h30); chk("halt_exit",   8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("halt_refetch",8'h11, 8'h00, 1'b1, 1'b0, 8'h01);

    // Branch on the halt edge flushes the halt word
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("flush_f1",    8'h22, 8'h01, 1'b1, 1'b0, 8'h02);
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("flush_word",  8'hFF, 8'h02, 1'b1, 1'b0, 8'h03);
    step(1'b0, 1'b0, 1'b1, 8'h10); chk("flush_bub",   8'h00, 8'h00, 1'b0, 1'b0, 8'h10);
    step(1'b0, 1'b0, 1'b0, 8'h00); chk("flush_tgt",   8'h77, 8'h10, 1'b1, 1'b0, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
